// File: rtl/sram_like_resp.sv
// In-order sram-like data responder: requests queue up, and each completes a fixed
// number of cycles after acceptance. Stores commit and loads read RAM at completion.
module sram_like_resp #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic             wr,
  input  logic [1:0]       size,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             addr_ok,
  output logic             data_ok,
  output logic [31:0]      rdata,
  input  logic             stall,
  output logic [CNT_W-1:0] pending_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  // The accept cycle itself counts as the first latency cycle.
  localparam logic [LAT_W-1:0] WAIT_INIT = LAT_W'(LATENCY - 1);

  logic [31:0]       mem [2**ADDR_W];

  logic [DEPTH-1:0]  vld_q;
  logic [LAT_W-1:0]  wait_q     [DEPTH];
  logic              ent_wr_q   [DEPTH];
  logic [3:0]        ent_strb_q [DEPTH];
  logic [ADDR_W-1:0] ent_idx_q  [DEPTH];
  logic [31:0]       ent_data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] req_idx;
  logic              unused_bits;

  assign req_idx     = addr[ADDR_W+1:2];
  assign unused_bits = ^{size, addr[1:0], addr[31:ADDR_W+2]};

  assign addr_ok     = resetn & ~stall & (cnt_q != FULL_CNT);
  assign data_ok     = resetn & vld_q[head_q] & (wait_q[head_q] == '0);
  assign push        = req & addr_ok;
  assign pop         = data_ok;
  assign rdata       = (data_ok & ~ent_wr_q[head_q]) ? mem[ent_idx_q[head_q]] : '0;
  assign pending_cnt = cnt_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop)  head_d = (DEPTH == 1) ? '0 : head_q + PTR_W'(1);
    if (push) tail_d = (DEPTH == 1) ? '0 : tail_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (pop)  vld_q[head_q] <= 1'b0;
      if (push) vld_q[tail_q] <= 1'b1;
    end
  end

  // Payload and wait counters need no reset; vld_q qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (wait_q[i] != '0)) wait_q[i] <= wait_q[i] - LAT_W'(1);
    end
    if (push) begin
      wait_q[tail_q]     <= WAIT_INIT;
      ent_wr_q[tail_q]   <= wr;
      ent_strb_q[tail_q] <= wstrb;
      ent_idx_q[tail_q]  <= req_idx;
      ent_data_q[tail_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (pop && ent_wr_q[head_q]) begin
      for (int b = 0; b < 4; b++) begin
        if (ent_strb_q[head_q][b])
          mem[ent_idx_q[head_q]][8*b +: 8] <= ent_data_q[head_q][8*b +: 8];
      end
    end
  end

endmodule
